// File: rtl/frame_tx.sv
// Serial frame transmitter: start bit (1), guard bit (0), DATA_W data bits MSB-first,
// then an optional forced-low gap. The line idles low; every output is a flop.
module frame_tx #(
    parameter int unsigned DATA_W  = 1,
    parameter int unsigned GAP_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              dout,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_GUARD = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BW-1:0]     bitCnt_q, bitCnt_d;
    logic [GW-1:0]     gapCnt_q, gapCnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;

    // Outputs are computed for the state being entered so they come straight off flops.
    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        gapCnt_d = gapCnt_q;
        shift_d  = shift_q;
        dout_d   = 1'b0;
        busy_d   = busy_q;
        ready_d  = ready_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && ready_q) begin
                    state_d  = S_START;
                    shift_d  = tx_data;
                    bitCnt_d = BW'(DATA_W - 1);
                    dout_d   = 1'b1;
                    busy_d   = 1'b1;
                    ready_d  = 1'b0;
                end
            end
            S_START: begin
                state_d = S_GUARD;
            end
            S_GUARD: begin
                state_d = S_DATA;
                dout_d  = shift_q[DATA_W-1];
                shift_d = shift_q << 1;
                done_d  = (bitCnt_q == '0);
            end
            S_DATA: begin
                // bitCnt_q counts data bits still to go after the one on the line now.
                if (bitCnt_q == '0) begin
                    if (GAP_CYC > 0) begin
                        state_d  = S_GAP;
                        gapCnt_d = GW'(GAP_CYC - 1);
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end else begin
                    bitCnt_d = bitCnt_q - BW'(1);
                    dout_d   = shift_q[DATA_W-1];
                    shift_d  = shift_q << 1;
                    done_d   = (bitCnt_q == BW'(1));
                end
            end
            S_GAP: begin
                if (gapCnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    gapCnt_d = gapCnt_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            bitCnt_q <= '0;
            gapCnt_q <= '0;
            shift_q  <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            gapCnt_q <= gapCnt_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign dout     = dout_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule
